disp_colr_adapt: RTL

Parametrised colour-depth adapter between the display pipeline (`disp_r/g/b`, `disp_hsync/vsync/de`, `disp_frame`) and the board TMDS encoder. It converts any `BPC_IN` to any `BPC_OUT`:
- Widening uses generalised bit replication.
- Narrowing uses truncation, optionally with 4×4 ordered (Bayer) dithering or temporal dithering, with saturation.

It has a fixed two-cycle pipeline, and sync/enable signals are delayed to match. It replaces hand-written per-board channel-width logic.

---
 rtl/disp_colr_pkg.sv | 21 ++
 rtl/disp_colr_adapt_if.sv | 30 +++
 rtl/bayer4_lut.sv | 25 ++
 rtl/disp_colr_adapt.sv | 133 +++++++++++++
 4 files changed

// File: rtl/disp_colr_pkg.sv
// Shared constants for the display colour-depth adapter: dither modes and the 4x4 Bayer table.
// Pure constants and a lookup helper; no clocked logic, no backpressure.
package disp_colr_pkg;

    localparam int DITHER_NONE     = 0;
    localparam int DITHER_ORDERED  = 1;
    localparam int DITHER_TEMPORAL = 2;

    // Nibble index is {y, x}; rows y0..y3 are 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
    localparam logic [63:0] BAYER4 = {
        4'd5,  4'd13, 4'd7,  4'd15,
        4'd9,  4'd1,  4'd11, 4'd3,
        4'd6,  4'd14, 4'd4,  4'd12,
        4'd10, 4'd2,  4'd8,  4'd0
    };

    function automatic logic [3:0] bayer_at(input logic [1:0] x, input logic [1:0] y);
        return BAYER4[{y, x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/disp_colr_adapt_if.sv
// Pixel bus into and out of the colour adapter; master is the pipeline side, slave is the adapter.
// Signal bundle only: no latency, one pixel per cycle, no backpressure.
interface disp_colr_adapt_if #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
);
    logic               in_hsync;
    logic               in_vsync;
    logic               in_de;
    logic               in_frame;
    logic [BPC_IN-1:0]  in_r;
    logic [BPC_IN-1:0]  in_g;
    logic [BPC_IN-1:0]  in_b;
    logic               out_hsync;
    logic               out_vsync;
    logic               out_de;
    logic [BPC_OUT-1:0] out_r;
    logic [BPC_OUT-1:0] out_g;
    logic [BPC_OUT-1:0] out_b;

    modport master (
        output in_hsync, in_vsync, in_de, in_frame, in_r, in_g, in_b,
        input  out_hsync, out_vsync, out_de, out_r, out_g, out_b
    );

    modport slave (
        input  in_hsync, in_vsync, in_de, in_frame, in_r, in_g, in_b,
        output out_hsync, out_vsync, out_de, out_r, out_g, out_b
    );
endinterface

// File: rtl/bayer4_lut.sv
// Combinational Bayer threshold scaled to D bits for an (xi, yi) position.
// Zero latency, no backpressure.
module bayer4_lut
    import disp_colr_pkg::*;
#(
    parameter int D = 1
) (
    input  logic [1:0]   xi_i,
    input  logic [1:0]   yi_i,
    output logic [D-1:0] t_o
);

    logic [3:0] b;

    assign b = bayer_at(xi_i, yi_i);

    generate
        if (D <= 4) begin : g_shr
            assign t_o = D'(b >> (4 - D));
        end else begin : g_shl
            assign t_o = D'(b) << (D - 4);
        end
    endgenerate

endmodule

// File: rtl/disp_colr_adapt.sv
// Colour-depth adapter: replicate to widen, truncate with optional ordered/temporal dither to narrow.
// Fixed 2-cycle latency on colour and syncs; no backpressure, one pixel per cycle.
module disp_colr_adapt
    import disp_colr_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int DITHER  = 0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    disp_colr_adapt_if.slave pix_io
);

    localparam bit NARROW   = (BPC_OUT < BPC_IN);
    localparam int D        = NARROW ? (BPC_IN - BPC_OUT) : 0;
    localparam int TW       = NARROW ? D : 1;
    localparam bit USE_T    = NARROW && (DITHER != DITHER_NONE);
    localparam bit TEMPORAL = (DITHER == DITHER_TEMPORAL);

    logic [1:0] xc_q, xc_d;
    logic [1:0] yc_q, yc_d;
    logic [1:0] fc_q, fc_d;
    logic [1:0] xi, yi;
    logic [TW-1:0] t_lut, t_d;

    logic                    hs1_q, vs1_q, de1_q;
    logic [2:0][BPC_IN-1:0]  c1_q;
    logic [TW-1:0]           t1_q;

    logic                    hs2_q, vs2_q, de2_q;
    logic [2:0][BPC_OUT-1:0] cv;
    logic [2:0][BPC_OUT-1:0] c2_q, c2_d;

    // de1_q doubles as the previous-cycle de for detecting the falling edge.
    always_comb begin
        xc_d = pix_io.in_de ? (xc_q + 2'd1) : 2'd0;
        yc_d = yc_q;
        if (pix_io.in_frame) begin
            yc_d = 2'd0;
        end else if (de1_q && !pix_io.in_de) begin
            yc_d = yc_q + 2'd1;
        end
        fc_d = 2'd0;
        if (TEMPORAL) begin
            fc_d = pix_io.in_frame ? (fc_q + 2'd1) : fc_q;
        end
    end

    always_comb begin
        xi = xc_q;
        yi = yc_q;
        if (TEMPORAL) begin
            xi = xc_q + fc_q;
            yi = yc_q + {fc_q[0], fc_q[1]};
        end
    end

    bayer4_lut #(.D(TW)) u_lut (
        .xi_i (xi),
        .yi_i (yi),
        .t_o  (t_lut)
    );

    assign t_d = USE_T ? t_lut : '0;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            xc_q  <= '0;
            yc_q  <= '0;
            fc_q  <= '0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            de1_q <= 1'b0;
            c1_q  <= '0;
            t1_q  <= '0;
        end else begin
            xc_q  <= xc_d;
            yc_q  <= yc_d;
            fc_q  <= fc_d;
            hs1_q <= pix_io.in_hsync;
            vs1_q <= pix_io.in_vsync;
            de1_q <= pix_io.in_de;
            c1_q  <= {pix_io.in_b, pix_io.in_g, pix_io.in_r};
            t1_q  <= t_d;
        end
    end

    generate
        if (!NARROW) begin : g_widen
            logic unused_t;
            assign unused_t = ^t1_q;
            for (genvar ch = 0; ch < 3; ch++) begin : g_ch
                for (genvar k = 0; k < BPC_OUT; k++) begin : g_bit
                    assign cv[ch][BPC_OUT-1-k] = c1_q[ch][BPC_IN-1-(k % BPC_IN)];
                end
            end
        end else begin : g_narrow
            // Sum carries one extra bit so a dithered full-scale input saturates instead of wrapping.
            localparam logic [BPC_IN:0] SAT = (BPC_IN + 1)'((1 << BPC_OUT) - 1);
            for (genvar ch = 0; ch < 3; ch++) begin : g_ch
                logic [BPC_IN:0] s, sh;
                assign s     = {1'b0, c1_q[ch]} + (BPC_IN + 1)'(t1_q);
                assign sh    = s >> D;
                assign cv[ch] = (sh > SAT) ? {BPC_OUT{1'b1}} : sh[BPC_OUT-1:0];
            end
        end
    endgenerate

    assign c2_d = de1_q ? cv : '0;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            de2_q <= 1'b0;
            c2_q  <= '0;
        end else begin
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= de1_q;
            c2_q  <= c2_d;
        end
    end

    assign pix_io.out_hsync = hs2_q;
    assign pix_io.out_vsync = vs2_q;
    assign pix_io.out_de    = de2_q;
    assign pix_io.out_r     = c2_q[0];
    assign pix_io.out_g     = c2_q[1];
    assign pix_io.out_b     = c2_q[2];

endmodule
